// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Optional build macro used by the arbiter: DMEM_ARB_STARVE_EN.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int LEN_W_DEF        = 8;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int BEAT_BYTES       = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dmem_burst_agu.sv
// Burst address generator: holds the word-aligned base, the beat count and
// the current beat index, and flags the final beat of a burst.
module dmem_burst_agu
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              step,
   output logic [ADDR_W-1:0] beat_addr,
   output logic              last_beat
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BEAT_BYTES) - ADDR_W'(1));
   localparam logic [LEN_W-1:0]  ONE_BEAT   = {{(LEN_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] base_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  beat_r;

   // Capture burst parameters on acceptance; advance the beat index per executed beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_r <= '0;
         len_r  <= '0;
         beat_r <= '0;
      end else if (load) begin
         base_r <= load_addr & ALIGN_MASK;
         len_r  <= (load_len == '0) ? ONE_BEAT : load_len;
         beat_r <= '0;
      end else if (step) begin
         beat_r <= beat_r + ONE_BEAT;
      end else begin
         beat_r <= beat_r;
      end
   end

   // Address wraps modulo 2^ADDR_W by plain truncation of the sum.
   assign beat_addr = base_r + (ADDR_W'(beat_r) * ADDR_W'(BEAT_BYTES));

   // Compare one bit wider so a full-length burst cannot alias on overflow.
   assign last_beat = ({1'b0, beat_r} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_r};

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage (zero-latency, priority) and
// a burst DMA master that uses the cycles the CPU leaves free.
// Optional build macro: DMEM_ARB_STARVE_EN (forces a DMA beat after
// STARVE_LIMIT consecutive lost beats, stalling the CPU for that cycle).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
`ifdef DMEM_ARB_STARVE_EN
   ,parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [LEN_W-1:0]  dma_len,
   output logic              dma_ack,
   output logic              dma_wready,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_done,
   output logic              busy,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   logic              ack_s;
   logic              load_s;
   logic              we_r;
   logic              force_s;
   logic              grant_d_s;
   logic [ADDR_W-1:0] beat_addr_s;
   logic              last_beat_s;
   logic              rvalid_r;
   logic [DATA_W-1:0] rdata_r;
   logic              done_r;

   assign grant_d_s = (state_r == ST_BURST) && (!cpu_req || force_s);

   dmem_burst_agu #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_agu (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .load_addr (dma_addr),
      .load_len  (dma_len),
      .step      (grant_d_s),
      .beat_addr (beat_addr_s),
      .last_beat (last_beat_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and burst acceptance; acceptance ignores cpu_req.
   always_comb begin
      state_nxt_s = state_r;
      ack_s       = 1'b0;
      load_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (dma_req && !reset) begin
               ack_s       = 1'b1;
               load_s      = 1'b1;
               state_nxt_s = ST_BURST;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (grant_d_s && last_beat_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BURST;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Burst direction captured at acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r <= 1'b0;
      end else if (load_s) begin
         we_r <= dma_we;
      end else begin
         we_r <= we_r;
      end
   end

   // Memory port mux: granted DMA beat first, then the CPU, else quiet bus.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      if (grant_d_s) begin
         mem_read  = !we_r;
         mem_write = we_r;
         mem_addr  = beat_addr_s;
         mem_wdata = dma_wdata;
      end else if (cpu_req) begin
         mem_read  = !cpu_we;
         mem_write = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         if (!cpu_we) begin
            cpu_rdata = mem_rdata;
         end else begin
            cpu_rdata = '0;
         end
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   // Read beat register plus end-of-burst pulse, both one cycle after the beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
         done_r   <= 1'b0;
      end else begin
         rvalid_r <= grant_d_s && !we_r;
         done_r   <= grant_d_s && last_beat_s;
         if (grant_d_s && !we_r) begin
            rdata_r <= mem_rdata;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

`ifdef DMEM_ARB_STARVE_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_r;

   // Count consecutive BURST cycles lost to the CPU; any DMA beat clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_r <= '0;
      end else if (grant_d_s) begin
         starve_r <= '0;
      end else if ((state_r == ST_BURST) && cpu_req) begin
         starve_r <= starve_r + {{(SC_W-1){1'b0}}, 1'b1};
      end else begin
         starve_r <= starve_r;
      end
   end

   assign force_s   = (state_r == ST_BURST) && (starve_r == SC_W'(STARVE_LIMIT));
   assign cpu_stall = cpu_req && grant_d_s;
`else
   assign force_s   = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   assign dma_ack    = ack_s;
   assign dma_wready = grant_d_s && we_r;
   assign dma_rvalid = rvalid_r;
   assign dma_rdata  = rdata_r;
   assign dma_done   = done_r;
   assign busy       = (state_r == ST_BURST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: CPU vector table, hand-written burst
// sequences, and randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

   localparam int TB_STARVE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr;
   logic [7:0]  dma_len;
   logic        dma_ack, dma_wready;
   logic [31:0] dma_wdata;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic        dma_done, busy;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
      .dma_ack(dma_ack), .dma_wready(dma_wready), .dma_wdata(dma_wdata),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
      .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // 256-word memory; the index wraps at 1 KiB so 0x400 maps to word 0.
   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
   end

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] e_rdata;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_maddr;
   } vec_t;
   vec_t vt [8];

   logic [31:0] ref_mem [0:255];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_len = 8'h0;
      dma_wdata = 32'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_cyc(input string tag, input logic e_ack, input logic e_busy,
                          input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic e_wready,
                          input logic e_rvalid, input logic [31:0] e_rdat,
                          input logic e_done, input logic [31:0] e_crd, input logic e_stall);
      @(negedge clk);
      chk({tag, ".ack"},       32'(dma_ack),    32'(e_ack));
      chk({tag, ".busy"},      32'(busy),       32'(e_busy));
      chk({tag, ".mem_read"},  32'(mem_read),   32'(e_rd));
      chk({tag, ".mem_write"}, 32'(mem_write),  32'(e_wr));
      chk({tag, ".mem_addr"},  mem_addr,        e_addr);
      if (e_wr) chk({tag, ".mem_wdata"}, mem_wdata, e_wdata);
      chk({tag, ".wready"},    32'(dma_wready), 32'(e_wready));
      chk({tag, ".rvalid"},    32'(dma_rvalid), 32'(e_rvalid));
      if (e_rvalid) chk({tag, ".rdata"}, dma_rdata, e_rdat);
      chk({tag, ".done"},      32'(dma_done),   32'(e_done));
      chk({tag, ".cpu_rdata"}, cpu_rdata,       e_crd);
      chk({tag, ".cpu_stall"}, 32'(cpu_stall),  32'(e_stall));
      next_cycle();
   endtask

   task automatic dma_start(input logic we, input logic [31:0] addr, input logic [7:0] len);
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_len = len;
   endtask

   // Randomized traffic against a transaction-level reference.
   task automatic run_random(input int ncyc);
      logic        m_active, m_we, p_rv, p_done, ack_m, force_m, grant, cpu_g;
      logic [31:0] m_base, p_rdata, e_addr, e_crd, e_wd;
      int          m_len, m_cnt, m_starve, pct;
      logic        e_rd, e_wr;
      m_active = 1'b0; m_we = 1'b0; p_rv = 1'b0; p_done = 1'b0; ack_m = 1'b0;
      m_base = 32'h0; p_rdata = 32'h0; m_len = 0; m_cnt = 0; m_starve = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int c = 0; c < ncyc; c++) begin
         if (ack_m) dma_req = 1'b0;
         if (c < ncyc - 20 && !dma_req && $urandom_range(0, 3) == 0) begin
            dma_start(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 5)));
         end
         pct = (c < ncyc / 2) ? 40 : 90;
         cpu_req   = (c < ncyc - 20) && ($urandom_range(0, 99) < pct);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         dma_wdata = $urandom;

         force_m = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
         force_m = m_active && (m_starve == TB_STARVE);
`endif
         grant = m_active && (!cpu_req || force_m);
         cpu_g = cpu_req && !grant;
         ack_m = !m_active && dma_req;
         if (grant) begin
            e_addr = m_base + 32'(m_cnt * 4); e_rd = !m_we; e_wr = m_we; e_wd = dma_wdata;
         end else if (cpu_g) begin
            e_addr = cpu_addr; e_rd = !cpu_we; e_wr = cpu_we; e_wd = cpu_wdata;
         end else begin
            e_addr = 32'h0; e_rd = 1'b0; e_wr = 1'b0; e_wd = 32'h0;
         end
         e_crd = (cpu_g && !cpu_we) ? ref_mem[cpu_addr[9:2]] : 32'h0;

         exp_cyc("rnd", ack_m, m_active, e_rd, e_wr, e_addr, e_wd, grant && m_we,
                 p_rv, p_rdata, p_done, e_crd, cpu_req && grant);

         p_rv = 1'b0; p_done = 1'b0;
         if (grant) begin
            if (m_we) ref_mem[e_addr[9:2]] = dma_wdata;
            else begin p_rv = 1'b1; p_rdata = ref_mem[e_addr[9:2]]; end
            m_cnt++; m_starve = 0;
            if (m_cnt == m_len) begin m_active = 1'b0; p_done = 1'b1; end
         end else begin
            if (cpu_g && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
            if (m_active && cpu_req) m_starve++;
         end
         if (ack_m) begin
            m_active = 1'b1; m_we = dma_we; m_base = dma_addr & ~32'h3;
            m_len = (dma_len == 8'h0) ? 1 : int'(dma_len); m_cnt = 0; m_starve = 0;
         end
      end
      idle_inputs();
   endtask

   initial begin
      vt[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'h10};
      vt[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h10};
      vt[2] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
      vt[3] = '{1'b1, 1'b1, 32'h84, 32'h9,        32'h0,        1'b0, 1'b1, 32'h84};
      vt[4] = '{1'b1, 1'b1, 32'h88, 32'h0,        32'h0,        1'b0, 1'b1, 32'h88};
      vt[5] = '{1'b1, 1'b1, 32'h8C, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h8C};
      vt[6] = '{1'b1, 1'b0, 32'h8C, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h8C};
      vt[7] = '{1'b1, 1'b0, 32'h86, 32'h0,        32'h9,        1'b1, 1'b0, 32'h86};

      // Reset, with a pending DMA request that must not be acknowledged.
      idle_inputs();
      reset = 1'b1;
      dma_req = 1'b1;
      next_cycle();
      exp_cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("reset.rdata", dma_rdata, 32'h0);
      next_cycle();
      dma_req = 1'b0;
      reset = 1'b0;

      // CPU-only vector table.
      for (int v = 0; v < 8; v++) begin
         cpu_req = vt[v].req; cpu_we = vt[v].we; cpu_addr = vt[v].addr; cpu_wdata = vt[v].wdata;
         exp_cyc("cpu_tbl", 1'b0, 1'b0, vt[v].e_rd, vt[v].e_wr, vt[v].e_maddr, vt[v].wdata,
                 1'b0, 1'b0, 32'h0, 1'b0, vt[v].e_rdata, 1'b0);
      end
      idle_inputs();

      // Uncontested 3-beat read from 0x84.
      dma_start(1'b0, 32'h84, 8'd3);
      exp_cyc("rd3.T0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle_inputs();
      exp_cyc("rd3.T1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("rd3.T2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1, 32'h9, 1'b0, 32'h0, 1'b0);
      exp_cyc("rd3.T3", 1'b0, 1'b1, 1'b1, 1'b0, 32'h8C, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("rd3.T4", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
      exp_cyc("rd3.T5", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Same burst with one CPU read stealing the T+2 slot.
      dma_start(1'b0, 32'h84, 8'd3);
      exp_cyc("cpu3.T0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle_inputs();
      exp_cyc("cpu3.T1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_addr = 32'h10;
      exp_cyc("cpu3.T2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h9, 1'b0, 32'hDEADBEEF, 1'b0);
      idle_inputs();
      exp_cyc("cpu3.T3", 1'b0, 1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("cpu3.T4", 1'b0, 1'b1, 1'b1, 1'b0, 32'h8C, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("cpu3.T5", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);

      // Unaligned 2-beat write that crosses the 1 KiB wrap point.
      dma_start(1'b1, 32'h3FE, 8'd2);
      exp_cyc("wr2.T0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle_inputs();
      dma_wdata = 32'hA5A50001;
      exp_cyc("wr2.T1", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3FC, 32'hA5A50001, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      dma_wdata = 32'hA5A50002;
      exp_cyc("wr2.T2", 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hA5A50002, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle_inputs();
      exp_cyc("wr2.T3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_addr = 32'h3FC;
      exp_cyc("wr2.rb255", 1'b0, 1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hA5A50001, 1'b0);
      cpu_addr = 32'h0;
      exp_cyc("wr2.rb0",   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hA5A50002, 1'b0);
      idle_inputs();

      // Reset in the middle of a 3-beat read aborts it without a done pulse.
      dma_start(1'b0, 32'h84, 8'd3);
      exp_cyc("rst.T0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle_inputs();
      exp_cyc("rst.T1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      exp_cyc("rst.T2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1, 32'h9, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      exp_cyc("rst.T3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("rst.T4", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Continuous CPU reads during a 2-beat read burst.
      dma_start(1'b0, 32'h84, 8'd2);
      cpu_req = 1'b1; cpu_addr = 32'h10;
      exp_cyc("hog.T0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
      dma_req = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      for (int k = 1; k <= 11; k++) begin
         logic        f;
         logic [31:0] a;
         f = (k % 5 == 0);
         a = f ? ((k == 5) ? 32'h84 : 32'h88) : 32'h10;
         exp_cyc("starve", 1'b0, k <= 10, 1'b1, 1'b0, a, 32'h0, 1'b0,
                 (k == 6) || (k == 11), (k == 6) ? 32'h9 : 32'h0, k == 11,
                 f ? 32'h0 : 32'hDEADBEEF, f);
      end
`else
      for (int k = 1; k <= 12; k++) begin
         exp_cyc("nostarve", 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'hDEADBEEF, 1'b0);
      end
      idle_inputs();
      exp_cyc("hog.B0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_cyc("hog.B1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1, 32'h9, 1'b0, 32'h0, 1'b0);
      exp_cyc("hog.D",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
`endif
      idle_inputs();
      next_cycle();

      run_random(800);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the CPU MEM stage (port C) and a burst DMA/loader master (port D). Sits between the pipeline, the DMA master and the data memory instance. CPU accesses are combinational and zero-latency. DMA bursts are accepted, address-sequenced and paced by the arbiter, and run in cycles the CPU leaves free.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
LEN_W, 8, DMA burst length field width (beats)
STARVE_LIMIT, 4, consecutive lost DMA beats before a forced DMA beat (feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access this cycle
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, same cycle
cpu_stall  out  1  CPU access not performed this cycle
dma_req  in  1  burst request, held until dma_ack
dma_we  in  1  burst direction
dma_addr  in  ADDR_W  burst byte base address
dma_len  in  LEN_W  beat count (0 treated as 1)
dma_ack  out  1  one-cycle acceptance pulse
dma_wready  out  1  current dma_wdata consumed this cycle
dma_wdata  in  DATA_W  write beat data
dma_rvalid  out  1  dma_rdata valid
dma_rdata  out  DATA_W  registered read beat
dma_done  out  1  one-cycle burst-complete pulse
busy  out  1  burst in progress
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_addr  out  ADDR_W  to memory Address
mem_wdata  out  DATA_W  to memory Write_data
mem_rdata  in  DATA_W  from memory Read_data (combinational)

Behaviour:
- Reset: state IDLE. dma_ack, dma_rvalid, dma_done, busy and cpu_stall = 0. dma_rdata = 0. Beat and starve counters = 0. Reset mid-burst aborts the burst with no dma_done.
- States: IDLE, BURST.
- grant_d = (state==BURST) && (!cpu_req || force). force=0 unless the feature is enabled.
- Memory mux, combinational:
  - grant_d: drives burst address/direction.
  - else cpu_req: drives CPU signals.
  - else mem_read = mem_write = 0.
  - Address and data are 0 when neither port is granted.
- cpu_rdata = mem_rdata when the CPU is granted a read, else 0.
- IDLE with dma_req: dma_ack=1. Latch base = {dma_addr[ADDR_W-1:2], 2'b00}, we, and len (0 becomes 1). Next state BURST, beat=0. Acceptance does not depend on cpu_req.
- BURST beat address = base + 4*beat, modulo 2^ADDR_W. The memory index wraps naturally, e.g. 0x3FC then 0x400, which maps to word 0.
- Each cycle with grant_d, one beat executes and beat increments.
  - Write: dma_wready=1 that cycle.
  - Read: dma_rvalid=1 and dma_rdata=mem_rdata on the next cycle.
- A cycle with cpu_req and !force pauses the burst: beat unchanged, no wready, no strobe.
- After the final beat, the next cycle: state=IDLE, dma_done=1. For reads, this coincides with the last dma_rvalid. dma_ack may assert in that same cycle for a queued dma_req.
- busy = (state==BURST).
- Latency: ack at T; earliest first beat at T+1; an uncontested N-beat burst has dma_done at T+N+1.

Optional Feature:
DMEM_ARB_STARVE_EN
- Enabled:
  - A counter increments on every BURST cycle with cpu_req && !grant_d, and clears on any DMA beat.
  - When the count equals STARVE_LIMIT, force=1 for one cycle: the DMA beat executes, cpu_stall=1, cpu_rdata=0, and the CPU write is suppressed. The counter then clears.
- Disabled: no counter; force=0; cpu_stall is constant 0. The CPU can starve a burst indefinitely.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE, BURST)
  - BEAT_BYTES=4
  - default widths
- Sub-module dmem_burst_agu holds:
  - base/len/beat registers
  - address generation
  - last-beat detect
- The top level keeps the FSM, mux, read register and starve logic.

Test Plan:
1. CPU only: write 0x10=0xDEADBEEF, then read 0x10 → cpu_rdata=0xDEADBEEF in the read cycle; dma outputs stay 0; cpu_stall=0.
2. DMA read, words 33..35 preloaded with 9, 0, 0xFFFFFFFF; dma_addr=0x84, len=3, ack at T → mem_addr 0x84/0x88/0x8C at T+1..T+3; rvalid T+2..T+4 with 9, 0, 0xFFFFFFFF; dma_done at T+4.
3. Same burst with cpu_req at T+2 → CPU serviced; 0x88 beat moves to T+3; no address skipped; dma_done at T+5.
4. DMA write dma_addr=0x3FE, len=2 → addresses 0x3FC then 0x400 (word 255, word 0); dma_wready high two cycles; done follows.
5. reset asserted at T+2 of a 3-beat read → next cycle IDLE, busy=0, no rvalid, no dma_done.
6. With DMEM_ARB_STARVE_EN, STARVE_LIMIT=4, cpu_req constant during a burst → fifth cycle gives a DMA beat with cpu_stall=1, repeating every 5 cycles. Without the macro → no beat, cpu_stall=0.
